// File: rtl/rom_mux_sync_pkg.sv
// Shared definitions for the arbitrated download-capable ROM: FSM state
// encodings and the index-width helper used by the top and the arbiter.
package rom_mux_pkg;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_LOAD = 1'b1;

  // Width of an index into n channels; never below one bit so NUM_CH=1 still
  // yields a legal vector.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/rom_mux_sync_rr_arbiter.sv
// Combinational round-robin picker: first eligible channel scanning upward
// from last_grant+1, wrapping modulo NUM_CH. The pointer lives in the parent.
module rr_arbiter
  import rom_mux_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned IW     = clog2_min1(NUM_CH)
) (
  input  logic [NUM_CH-1:0] elig,
  input  logic [IW-1:0]     last_grant,
  output logic [NUM_CH-1:0] gnt,
  output logic [IW-1:0]     gnt_idx
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      cand = IW'((32'(last_grant) + k) % NUM_CH);
      if (!found && elig[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rom_mux_sync.sv
// Block-RAM ROM shared by NUM_CH read clients via round-robin arbitration,
// with a download write port that stalls all reads while active.
module rom_mux_sync
  import rom_mux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 15,
  parameter int unsigned NUM_CH        = 2,
  parameter              DATA_HEX_FILE = ""
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dl_en,
  input  logic                         dl_we,
  input  logic [ADDR_WIDTH-1:0]        dl_addr,
  input  logic [DATA_WIDTH-1:0]        dl_data,
  input  logic [NUM_CH-1:0]            ch_req,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
  output logic [NUM_CH-1:0]            ch_ack,
  output logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  output logic                         ready
);

  localparam int unsigned IW    = clog2_min1(NUM_CH);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [0:0]            state;
  logic                  grant_ok;
  logic [NUM_CH-1:0]     elig;
  logic [NUM_CH-1:0]     gnt;
  logic [IW-1:0]         gnt_idx;
  logic [IW-1:0]         last_grant;
  logic [NUM_CH-1:0]     pend_q;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else if (state == ST_RUN && dl_en) begin
      state <= ST_LOAD;
    end else if (state == ST_LOAD && !dl_en) begin
      state <= ST_RUN;
    end
  end

  assign ready = (state == ST_RUN) && !rst;

  // pend_q marks the channel granted last cycle; excluding it keeps a held
  // request from being granted again before its ack is visible.
  assign grant_ok = (state == ST_RUN) && !dl_en;
  assign elig     = ch_req & ~pend_q & {NUM_CH{grant_ok}};

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IW     (IW)
  ) u_arb (
    .elig       (elig),
    .last_grant (last_grant),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  always_comb begin
    rd_addr = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) rd_addr = ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (dl_en && dl_we) mem[dl_addr] <= dl_data;
  end

  always_ff @(posedge clk) begin
    if (|gnt) rd_q <= mem[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= '0;
      last_grant <= IW'(NUM_CH - 1);
      ch_ack     <= '0;
      ch_data    <= '0;
    end else begin
      pend_q <= gnt;
      if (|gnt) last_grant <= gnt_idx;
      ch_ack <= pend_q;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (pend_q[i]) ch_data[i*DATA_WIDTH +: DATA_WIDTH] <= rd_q;
      end
    end
  end

endmodule
